// File: rtl/n64_poll_sequencer.sv
// n64_poll_sequencer
//   Schedules periodic polls of one N64 controller port. Each poll triggers
//   n64_cmd_gen, tracks the command phase through the generator's output
//   enable, then decodes the 32-bit reply from the pulled-up data pin.
//   Each reply bit is sampled 2 us after its falling edge:
//   1 us low = '1', 3 us low = '0'.
//
//   Ports
//     clk          system clock
//     rst_n        asynchronous active-low reset
//     enable       1 = polling active
//     cmd_busy     n64_cmd_gen enable_o (1 while the command is driven)
//     cmd_trigger  trigger to n64_cmd_gen
//     din          data pin input (idle high)
//     data_out     last good reply, bit 0 = last received bit
//     data_valid   1-cycle pulse coincident with a data_out update
//     timeout_err  1-cycle pulse when a poll is aborted on timeout
//     busy         1 while the sequencer is not idle
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | count us ticks toward the next poll
//   TRIG    | hold cmd_trigger for one full 1 MHz period
//   TX      | command on the pin; wait for cmd_busy to rise, then fall
//   RX_WAIT | wait for the falling edge that starts the next reply bit
//   RX_BIT  | count to the 2 us sample point, then shift in the bit
//   DONE    | publish the reply
//   ERR     | report an aborted poll
module n64_poll_sequencer #(
   parameter int SAMPLE_DIV     = 12,
   parameter int POLL_PERIOD_US = 512,
   parameter int RESP_BITS      = 32,
   parameter int TIMEOUT_US     = 64,
   parameter int CMD_TMO_US     = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        cmd_busy,
   output logic        cmd_trigger,
   input  logic        din,
   output logic [31:0] data_out,
   output logic        data_valid,
   output logic        timeout_err,
   output logic        busy
);

   localparam int TMO_MAX = (TIMEOUT_US > CMD_TMO_US) ? TIMEOUT_US : CMD_TMO_US;
   localparam int US_W    = $clog2(SAMPLE_DIV) + 1;
   localparam int POLL_W  = $clog2(POLL_PERIOD_US) + 1;
   localparam int TMO_W   = $clog2(TMO_MAX) + 1;
   localparam int BIT_W   = $clog2(RESP_BITS) + 1;
   localparam int SMP_W   = $clog2(2 * SAMPLE_DIV) + 1;

   localparam logic [US_W-1:0]   US_LAST   = US_W'(SAMPLE_DIV - 1);
   localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_PERIOD_US - 1);
   localparam logic [TMO_W-1:0]  RX_LAST   = TMO_W'(TIMEOUT_US - 1);
   localparam logic [TMO_W-1:0]  CMD_LAST  = TMO_W'(CMD_TMO_US - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(RESP_BITS - 1);
   localparam logic [SMP_W-1:0]  SMP_LOAD  = SMP_W'(2 * SAMPLE_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_TRIG, S_TX, S_RX_WAIT, S_RX_BIT, S_DONE, S_ERR
   } state_t;

   state_t            state, state_nxt;
   logic              din_s1, din_s2, din_prev;
   logic              busy_s1, busy_s2;
   logic              din_fall, us_tick;
   logic [US_W-1:0]   us_cnt;
   logic [POLL_W-1:0] poll_cnt, poll_nxt;
   logic [TMO_W-1:0]  tmo, tmo_nxt;
   logic [SMP_W-1:0]  smp, smp_nxt;
   logic [BIT_W-1:0]  bit_cnt, bit_nxt;
   logic [31:0]       sr, sr_nxt, data_nxt;
   logic              seen, seen_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         din_s1   <= 1'b1;
         din_s2   <= 1'b1;
         din_prev <= 1'b1;
         busy_s1  <= 1'b0;
         busy_s2  <= 1'b0;
         us_cnt   <= '0;
      end else begin
         din_s1   <= din;
         din_s2   <= din_s1;
         din_prev <= din_s2;
         busy_s1  <= cmd_busy;
         busy_s2  <= busy_s1;
         us_cnt   <= (us_cnt == US_LAST) ? '0 : us_cnt + US_W'(1);
      end
   end

   assign din_fall = din_prev & ~din_s2;
   assign us_tick  = (us_cnt == US_LAST);

   always_comb begin
      state_nxt = state;
      poll_nxt  = '0;
      tmo_nxt   = tmo;
      smp_nxt   = smp;
      bit_nxt   = bit_cnt;
      sr_nxt    = sr;
      seen_nxt  = seen;
      data_nxt  = data_out;
      case (state)
         S_IDLE: begin
            poll_nxt = poll_cnt;
            if (us_tick) begin
               if (poll_cnt == POLL_LAST) begin
                  poll_nxt  = '0;
                  state_nxt = S_TRIG;
               end else begin
                  poll_nxt = poll_cnt + POLL_W'(1);
               end
            end
            if (!enable) poll_nxt = '0;
         end
         S_TRIG: begin
            if (us_tick) begin
               state_nxt = S_TX;
               tmo_nxt   = '0;
               seen_nxt  = 1'b0;
            end
         end
         S_TX: begin
            if (busy_s2) seen_nxt = 1'b1;
            if (seen && !busy_s2) begin
               state_nxt = S_RX_WAIT;
               tmo_nxt   = '0;
               bit_nxt   = '0;
               sr_nxt    = '0;
            end else if (!seen && !busy_s2 && us_tick) begin
               if (tmo == CMD_LAST) state_nxt = S_ERR;
               else                 tmo_nxt   = tmo + TMO_W'(1);
            end
         end
         S_RX_WAIT: begin
            if (din_fall) begin
               state_nxt = S_RX_BIT;
               smp_nxt   = SMP_LOAD;
            end else if (us_tick) begin
               if (tmo == RX_LAST) state_nxt = S_ERR;
               else                tmo_nxt   = tmo + TMO_W'(1);
            end
         end
         S_RX_BIT: begin
            if (smp == '0) begin
               sr_nxt  = {sr[30:0], din_s2};
               bit_nxt = bit_cnt + BIT_W'(1);
               if (bit_cnt == BIT_LAST) begin
                  state_nxt = S_DONE;
               end else begin
                  state_nxt = S_RX_WAIT;
                  tmo_nxt   = '0;
               end
            end else begin
               smp_nxt = smp - SMP_W'(1);
            end
         end
         S_DONE: begin
            data_nxt  = sr;
            state_nxt = S_IDLE;
         end
         S_ERR: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      // Dropping enable abandons the poll silently, whatever it was doing.
      if (!enable) begin
         state_nxt = S_IDLE;
         data_nxt  = data_out;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         poll_cnt    <= '0;
         tmo         <= '0;
         smp         <= '0;
         bit_cnt     <= '0;
         sr          <= '0;
         seen        <= 1'b0;
         data_out    <= '0;
         data_valid  <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         poll_cnt    <= poll_nxt;
         tmo         <= tmo_nxt;
         smp         <= smp_nxt;
         bit_cnt     <= bit_nxt;
         sr          <= sr_nxt;
         seen        <= seen_nxt;
         data_out    <= data_nxt;
         // Pulses are registered so data_valid lines up with the new data_out.
         data_valid  <= (state == S_DONE) && enable;
         timeout_err <= (state == S_ERR) && enable;
      end
   end

   assign cmd_trigger = (state == S_TRIG);
   assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_n64_poll_sequencer.sv
`timescale 1ns/1ps
module tb_n64_poll_sequencer;
   localparam int US   = 6;
   localparam int POLL = 512;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        cmd_busy = 1'b0;
   logic        din = 1'b1;
   logic        cmd_trigger, data_valid, timeout_err, busy;
   logic [31:0] data_out;

   n64_poll_sequencer #(
      .SAMPLE_DIV(US), .POLL_PERIOD_US(POLL), .RESP_BITS(32),
      .TIMEOUT_US(64), .CMD_TMO_US(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .cmd_busy(cmd_busy),
      .cmd_trigger(cmd_trigger), .din(din), .data_out(data_out),
      .data_valid(data_valid), .timeout_err(timeout_err), .busy(busy)
   );

   always #5 clk = ~clk;

   // kind: 1 = data_valid, 2 = timeout_err, 3 = both at once
   typedef struct {
      int          kind;
      logic [31:0] data;
      longint      cyc;
   } ev_t;

   ev_t         exp_q[$];
   ev_t         obs_q[$];
   longint      cyc = 0;
   longint      trig_rise_cyc = 0;
   longint      trig_fall_cyc = 0;
   int          trig_rises = 0;
   int          n_valid = 0;
   int          n_err = 0;
   logic        trig_prev = 1'b0;
   int          pass_cnt = 0;
   int          total_cnt = 0;
   logic [31:0] last_good = 32'h0;
   bit          have_trig = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (data_valid || timeout_err)
         obs_q.push_back('{(data_valid && timeout_err) ? 3 : (data_valid ? 1 : 2),
                           data_out, cyc});
      if (data_valid)  n_valid <= n_valid + 1;
      if (timeout_err) n_err   <= n_err + 1;
      if (cmd_trigger && !trig_prev) begin
         trig_rises    <= trig_rises + 1;
         trig_rise_cyc <= cyc;
      end
      if (!cmd_trigger && trig_prev) trig_fall_cyc <= cyc;
      trig_prev <= cmd_trigger;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_trig(output bit ok);
      int start;
      start = trig_rises;
      ok = 1'b0;
      for (int i = 0; i < 700 * US; i++) begin
         tick(1);
         if (trig_rises != start) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         total_cnt++;
         $display("FAIL trigger_wait: no cmd_trigger rise within 700 us, required one");
      end
   endtask

   task automatic start_poll(output bit ok);
      if (have_trig) begin
         have_trig = 1'b0;
         ok = 1'b1;
      end else begin
         wait_trig(ok);
      end
   endtask

   task automatic wait_event(input int max_cyc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         if (obs_q.size() > 0) begin
            ok = 1'b1;
            break;
         end
         tick(1);
      end
      if (!ok) begin
         total_cnt++;
         $display("FAIL event_wait: no data_valid/timeout_err within %0d cycles", max_cyc);
      end
   endtask

   // cmd_busy high for 25 us, with the command echo toggling the shared pin.
   task automatic serve_cmd();
      tick(US);
      cmd_busy = 1'b1;
      for (int i = 0; i < 6; i++) begin
         din = 1'b0; tick(US);
         din = 1'b1; tick(3 * US);
      end
      tick(US);
      cmd_busy = 1'b0;
   endtask

   task automatic send_bits(input logic [31:0] w, input int n);
      for (int i = 0; i < n; i++) begin
         din = 1'b0; tick(w[31-i] ? US : 3 * US);
         din = 1'b1; tick(w[31-i] ? 3 * US : US);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b0; cmd_busy = 1'b0; din = 1'b1;
      tick(3);
      total_cnt++;
      if ({cmd_trigger, data_valid, timeout_err, busy} !== 4'b0000)
         $display("FAIL reset_ctrl: trig/valid/err/busy=%b required 0000",
                  {cmd_trigger, data_valid, timeout_err, busy});
      else pass_cnt++;
      total_cnt++;
      if (data_out !== 32'h0) $display("FAIL reset_data: data_out=%h required 0", data_out);
      else pass_cnt++;
      rst_n = 1'b1;
      tick(2);
   endtask

   task automatic test_basic();
      bit ok;
      longint t0, d;
      ev_t e, x;
      logic [31:0] w;
      w = 32'h800100FF;
      enable = 1'b1;
      t0 = cyc;
      wait_trig(ok);
      if (!ok) return;
      d = trig_rise_cyc - t0;
      total_cnt++;
      if (d < 511 * US || d > 512 * US + 2)
         $display("FAIL first_trigger: %0d cycles after enable, required ~%0d", d, 512 * US);
      else pass_cnt++;
      serve_cmd();
      total_cnt++;
      if (trig_fall_cyc - trig_rise_cyc != US)
         $display("FAIL trigger_width: %0d cycles required %0d", trig_fall_cyc - trig_rise_cyc, US);
      else pass_cnt++;
      tick(2 * US);
      exp_q.push_back('{1, w, 0});
      send_bits(w, 32);
      wait_event(10 * US, ok);
      if (!ok) return;
      e = exp_q.pop_front();
      x = obs_q.pop_front();
      total_cnt++;
      if (x.kind !== e.kind) $display("FAIL basic_kind: event %0d required %0d", x.kind, e.kind);
      else pass_cnt++;
      total_cnt++;
      if (x.data !== e.data) $display("FAIL basic_data: data_out=%h required %h", x.data, e.data);
      else pass_cnt++;
      tick(2);
      total_cnt++;
      if (data_out !== w) $display("FAIL basic_hold: data_out=%h required %h", data_out, w);
      else pass_cnt++;
      last_good = w;
      wait_trig(ok);
      if (!ok) return;
      d = trig_rise_cyc - x.cyc;
      total_cnt++;
      if (d < 511 * US || d > 512 * US + 1)
         $display("FAIL next_trigger: %0d cycles after IDLE entry, required ~%0d", d, 512 * US);
      else pass_cnt++;
      have_trig = 1'b1;
   endtask

   task automatic test_back_to_back();
      bit ok;
      ev_t e, x;
      int v0, e0;
      logic [31:0] words [2];
      words[0] = 32'hFFFFFFFF;
      words[1] = 32'h00000000;
      v0 = n_valid;
      e0 = n_err;
      for (int k = 0; k < 2; k++) begin
         start_poll(ok);
         if (!ok) return;
         serve_cmd();
         tick(2 * US);
         exp_q.push_back('{1, words[k], 0});
         send_bits(words[k], 32);
         wait_event(10 * US, ok);
         if (!ok) return;
         e = exp_q.pop_front();
         x = obs_q.pop_front();
         total_cnt++;
         if (x.kind !== e.kind) $display("FAIL b2b_kind%0d: event %0d required %0d", k, x.kind, e.kind);
         else pass_cnt++;
         total_cnt++;
         if (x.data !== e.data) $display("FAIL b2b_data%0d: data_out=%h required %h", k, x.data, e.data);
         else pass_cnt++;
         last_good = words[k];
      end
      tick(2);
      total_cnt++;
      if (n_valid - v0 != 2) $display("FAIL b2b_valid_count: %0d required 2", n_valid - v0);
      else pass_cnt++;
      total_cnt++;
      if (n_err - e0 != 0) $display("FAIL b2b_err_count: %0d required 0", n_err - e0);
      else pass_cnt++;
   endtask

   task automatic test_truncated();
      bit ok;
      ev_t e, x;
      int v0;
      logic [31:0] w;
      start_poll(ok);
      if (!ok) return;
      serve_cmd();
      tick(2 * US);
      v0 = n_valid;
      exp_q.push_back('{2, last_good, 0});
      send_bits(32'hA5A55A5A, 16);
      wait_event(80 * US, ok);
      if (!ok) return;
      e = exp_q.pop_front();
      x = obs_q.pop_front();
      total_cnt++;
      if (x.kind !== e.kind) $display("FAIL trunc_kind: event %0d required %0d", x.kind, e.kind);
      else pass_cnt++;
      total_cnt++;
      if (x.data !== e.data) $display("FAIL trunc_data: data_out=%h required %h", x.data, e.data);
      else pass_cnt++;
      total_cnt++;
      if (n_valid != v0) $display("FAIL trunc_no_valid: %0d valid pulses required 0", n_valid - v0);
      else pass_cnt++;
      w = 32'h12345678;
      start_poll(ok);
      if (!ok) return;
      serve_cmd();
      tick(2 * US);
      exp_q.push_back('{1, w, 0});
      send_bits(w, 32);
      wait_event(10 * US, ok);
      if (!ok) return;
      e = exp_q.pop_front();
      x = obs_q.pop_front();
      total_cnt++;
      if (x.kind !== e.kind) $display("FAIL recover_kind: event %0d required %0d", x.kind, e.kind);
      else pass_cnt++;
      total_cnt++;
      if (x.data !== e.data) $display("FAIL recover_data: data_out=%h required %h", x.data, e.data);
      else pass_cnt++;
      last_good = w;
   endtask

   task automatic test_no_reply();
      bit ok;
      ev_t e, x;
      longint t0, d;
      start_poll(ok);
      if (!ok) return;
      serve_cmd();
      t0 = cyc;
      exp_q.push_back('{2, last_good, 0});
      wait_event(80 * US, ok);
      if (!ok) return;
      e = exp_q.pop_front();
      x = obs_q.pop_front();
      total_cnt++;
      if (x.kind !== e.kind) $display("FAIL noreply_kind: event %0d required %0d", x.kind, e.kind);
      else pass_cnt++;
      total_cnt++;
      if (x.data !== e.data) $display("FAIL noreply_retain: data_out=%h required %h", x.data, e.data);
      else pass_cnt++;
      d = x.cyc - t0;
      total_cnt++;
      if (d < 63 * US || d > 65 * US + 1)
         $display("FAIL noreply_delay: %0d cycles required ~%0d", d, 64 * US);
      else pass_cnt++;
   endtask

   task automatic test_no_cmd_busy();
      bit ok;
      ev_t e, x;
      longint d;
      start_poll(ok);
      if (!ok) return;
      exp_q.push_back('{2, last_good, 0});
      wait_event(30 * US, ok);
      if (!ok) return;
      e = exp_q.pop_front();
      x = obs_q.pop_front();
      total_cnt++;
      if (x.kind !== e.kind) $display("FAIL nocmd_kind: event %0d required %0d", x.kind, e.kind);
      else pass_cnt++;
      d = x.cyc - trig_fall_cyc;
      total_cnt++;
      if (d < 15 * US || d > 16 * US + 2)
         $display("FAIL nocmd_delay: %0d cycles after TRIG exit required ~%0d", d, 16 * US);
      else pass_cnt++;
   endtask

   task automatic test_enable_and_reset();
      bit ok;
      longint t0, d;
      int v0, e0;
      start_poll(ok);
      if (!ok) return;
      serve_cmd();
      tick(2 * US);
      v0 = n_valid;
      e0 = n_err;
      send_bits(32'hCAFEF00D, 10);
      din = 1'b0;
      tick(US);
      enable = 1'b0;
      tick(1);
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL disable_busy: busy=%b required 0", busy);
      else pass_cnt++;
      din = 1'b1;
      tick(80 * US);
      total_cnt++;
      if ((n_valid - v0) + (n_err - e0) != 0 || obs_q.size() != 0)
         $display("FAIL disable_pulses: %0d valid %0d err required 0 0", n_valid - v0, n_err - e0);
      else pass_cnt++;
      total_cnt++;
      if (data_out !== last_good) $display("FAIL disable_retain: data_out=%h required %h", data_out, last_good);
      else pass_cnt++;
      enable = 1'b1;
      wait_trig(ok);
      if (!ok) return;
      tick(US);
      cmd_busy = 1'b1;
      tick(5 * US);
      #2;
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({cmd_trigger, data_valid, timeout_err, busy} !== 4'b0000)
         $display("FAIL midtx_reset_ctrl: trig/valid/err/busy=%b required 0000",
                  {cmd_trigger, data_valid, timeout_err, busy});
      else pass_cnt++;
      total_cnt++;
      if (data_out !== 32'h0) $display("FAIL midtx_reset_data: data_out=%h required 0", data_out);
      else pass_cnt++;
      cmd_busy = 1'b0;
      tick(3);
      rst_n = 1'b1;
      t0 = cyc;
      wait_trig(ok);
      if (!ok) return;
      d = trig_rise_cyc - t0;
      total_cnt++;
      if (d < 511 * US || d > 512 * US + 2)
         $display("FAIL post_reset_trigger: %0d cycles required ~%0d", d, 512 * US);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_truncated();
      test_no_reply();
      test_no_cmd_busy();
      test_enable_and_reset();
      tick(2);
      total_cnt++;
      if (obs_q.size() != 0 || exp_q.size() != 0)
         $display("FAIL scoreboard_drain: %0d observed %0d expected left, required 0 0",
                  obs_q.size(), exp_q.size());
      else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
